// File: rtl/nn_axi_pkg.sv
// ---------------------------------------------------------------------------
// nn_axi_pkg
//
// Shared definitions for the NN accelerator AXI4-Lite register block:
//   - byte offsets of every register in the 32-byte map
//   - the word index (byte offset bits [4:2]) the decoder actually compares
//   - AXI response code
//   - write/read channel state encodings
// ---------------------------------------------------------------------------
package nn_axi_pkg;

    // Byte offsets of the register map.
    localparam logic [4:0] ADDR_WEIGHT = 5'h00;
    localparam logic [4:0] ADDR_BIAS   = 5'h04;
    localparam logic [4:0] ADDR_RESULT = 5'h08;
    localparam logic [4:0] ADDR_LAYER  = 5'h0C;
    localparam logic [4:0] ADDR_NEURON = 5'h10;
    localparam logic [4:0] ADDR_NOUT   = 5'h14;
    localparam logic [4:0] ADDR_STATUS = 5'h18;
    localparam logic [4:0] ADDR_CTRL   = 5'h1C;

    // Word indices; the byte lanes [1:0] never take part in decode.
    localparam logic [2:0] IDX_WEIGHT = ADDR_WEIGHT[4:2];
    localparam logic [2:0] IDX_BIAS   = ADDR_BIAS[4:2];
    localparam logic [2:0] IDX_RESULT = ADDR_RESULT[4:2];
    localparam logic [2:0] IDX_LAYER  = ADDR_LAYER[4:2];
    localparam logic [2:0] IDX_NEURON = ADDR_NEURON[4:2];
    localparam logic [2:0] IDX_NOUT   = ADDR_NOUT[4:2];
    localparam logic [2:0] IDX_STATUS = ADDR_STATUS[4:2];
    localparam logic [2:0] IDX_CTRL   = ADDR_CTRL[4:2];

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Write channel: idle -> accept (awready/wready high) -> response (bvalid high).
    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_ACCEPT = 2'd1,
        WR_RESP   = 2'd2
    } wr_state_t;

    // Read channel: idle -> accept (arready high) -> data (rvalid high).
    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_ACCEPT = 2'd1,
        RD_DATA   = 2'd2
    } rd_state_t;

    // Word index of a byte address.
    function automatic logic [2:0] reg_index(input logic [4:0] byte_addr);
        return byte_addr[4:2];
    endfunction

endpackage

// File: rtl/nn_axi_lite_slave.sv
// ---------------------------------------------------------------------------
// nn_axi_lite_slave
//
// AXI4-Lite responder that owns the NN accelerator register map.
//
// Ports:
//   s_axi_aclk / s_axi_aresetn   clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* / s_axi_b*   write address, data and response channels
//   s_axi_ar* / s_axi_r*              read address and data channels
//   weightValid / weightValue    one-cycle strobe + weight word (offset 0x00)
//   biasValid / biasValue        one-cycle strobe + bias word (offset 0x04)
//   config_layer_num             layer select (offset 0x0C, R/W)
//   config_neuron_num            neuron select (offset 0x10, R/W)
//   softReset                    one-cycle strobe on control write bit0 (0x1C)
//   result / result_valid        classification result from the max-finder
//   neuron_out                   flat final-layer outputs, neuron 0 in LSBs
//   intr                         level interrupt: a result is pending
//   dbg_wr_state / dbg_rd_state  current write / read channel state
//
// Handshake semantics: a transfer on any channel happens on the rising edge
// where both valid and ready are high. This block raises awready/wready
// (together) or arready for exactly one cycle, one cycle after it sees the
// request, and expects the master to hold valid and payload until then.
// bvalid/rvalid, once raised, stay high with stable payload until the master
// samples bready/rready high. A new write is not taken while bvalid is high,
// and a new read is not taken while rvalid is high. The two channels are
// fully independent.
// ---------------------------------------------------------------------------
module nn_axi_lite_slave
    import nn_axi_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH         = 16,
    parameter int NUM_OUT            = 10
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    // write address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    // write data channel
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [3:0]                      s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    // write response channel
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    // read address channel
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    // read data channel
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    // configuration outputs
    output logic                            weightValid,
    output logic [DATA_WIDTH-1:0]           weightValue,
    output logic                            biasValid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   biasValue,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   config_layer_num,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   config_neuron_num,
    output logic                            softReset,
    // result inputs
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   result,
    input  logic                            result_valid,
    input  logic [NUM_OUT*DATA_WIDTH-1:0]   neuron_out,
    output logic                            intr,
    // state visibility
    output logic [1:0]                      dbg_wr_state,
    output logic [1:0]                      dbg_rd_state
);

    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OUT - 1);

    wr_state_t wr_state, wr_state_next;
    rd_state_t rd_state, rd_state_next;

    logic                          wr_fire;
    logic                          rd_fire;
    logic [2:0]                    wr_idx;
    logic [2:0]                    rd_idx;
    logic                          ctrl_clear;
    logic                          result_read;
    logic [IDX_W-1:0]              out_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] result_q;
    logic [DATA_WIDTH-1:0]         nout_word;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux;

    // Protection bits and byte strobes carry no meaning for this map.
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb};

    assign wr_idx = reg_index(s_axi_awaddr[4:0]);
    assign rd_idx = reg_index(s_axi_araddr[4:0]);

    assign s_axi_bresp  = RESP_OKAY;
    assign s_axi_rresp  = RESP_OKAY;
    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

    // ------------------------------------------------------------------
    // Write channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            wr_state <= WR_IDLE;
        end else begin
            wr_state <= wr_state_next;
        end
    end

    always_comb begin
        wr_state_next = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        wr_fire       = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                // Address and data must both be present; one alone waits.
                if (s_axi_awvalid && s_axi_wvalid) begin
                    wr_state_next = WR_ACCEPT;
                end
            end
            WR_ACCEPT: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                wr_fire       = s_axi_awvalid && s_axi_wvalid;
                // A master that withdrew its request gets nothing.
                wr_state_next = wr_fire ? WR_RESP : WR_IDLE;
            end
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    wr_state_next = WR_IDLE;
                end
            end
            default: begin
                wr_state_next = WR_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rd_state <= RD_IDLE;
        end else begin
            rd_state <= rd_state_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        rd_fire       = 1'b0;
        case (rd_state)
            RD_IDLE: begin
                if (s_axi_arvalid) begin
                    rd_state_next = RD_ACCEPT;
                end
            end
            RD_ACCEPT: begin
                s_axi_arready = 1'b1;
                rd_fire       = s_axi_arvalid;
                rd_state_next = rd_fire ? RD_DATA : RD_IDLE;
            end
            RD_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: begin
                rd_state_next = RD_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Write decode: register and strobe updates land in the first bvalid
    // cycle, because they are loaded on the handshake edge.
    // ------------------------------------------------------------------
    assign ctrl_clear = wr_fire && (wr_idx == IDX_CTRL) && s_axi_wdata[0];

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            weightValid       <= 1'b0;
            weightValue       <= '0;
            biasValid         <= 1'b0;
            biasValue         <= '0;
            config_layer_num  <= '0;
            config_neuron_num <= '0;
            softReset         <= 1'b0;
        end else begin
            weightValid <= 1'b0;
            biasValid   <= 1'b0;
            softReset   <= ctrl_clear;
            if (wr_fire) begin
                case (wr_idx)
                    IDX_WEIGHT: begin
                        weightValue <= s_axi_wdata[DATA_WIDTH-1:0];
                        weightValid <= 1'b1;
                    end
                    IDX_BIAS: begin
                        biasValue <= s_axi_wdata;
                        biasValid <= 1'b1;
                    end
                    IDX_LAYER:  config_layer_num  <= s_axi_wdata;
                    IDX_NEURON: config_neuron_num <= s_axi_wdata;
                    // Read-only and control offsets leave these registers alone.
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Result latch, interrupt and neuron-output read pointer
    // ------------------------------------------------------------------
    assign result_read = rd_fire && (rd_idx == IDX_RESULT);

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            result_q <= '0;
            intr     <= 1'b0;
            out_idx  <= '0;
        end else begin
            if (result_valid) begin
                result_q <= result;
            end

            // A fresh result outranks any clear arriving in the same cycle,
            // so the host can never lose a pending notification.
            if (result_valid) begin
                intr <= 1'b1;
            end else if (result_read || ctrl_clear) begin
                intr <= 1'b0;
            end

            if (result_valid || ctrl_clear) begin
                out_idx <= '0;
            end else if (rd_fire && (rd_idx == IDX_NOUT)) begin
                out_idx <= (out_idx == IDX_LAST) ? '0 : out_idx + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    always_comb begin
        nout_word = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (out_idx == IDX_W'(i)) begin
                nout_word = neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            IDX_RESULT: rd_mux = result_q;
            IDX_LAYER:  rd_mux = config_layer_num;
            IDX_NEURON: rd_mux = config_neuron_num;
            IDX_NOUT:   rd_mux = {{(C_S_AXI_DATA_WIDTH-DATA_WIDTH){nout_word[DATA_WIDTH-1]}},
                                  nout_word};
            IDX_STATUS: rd_mux = {{(C_S_AXI_DATA_WIDTH-2){1'b0}}, (out_idx != '0), intr};
            default:    rd_mux = '0;
        endcase
    end

    // rdata only loads on the address handshake, so it stays frozen for the
    // whole time rvalid is high.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            s_axi_rdata <= '0;
        end else if (rd_fire) begin
            s_axi_rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_nn_axi_lite_slave.sv
module tb_nn_axi_lite_slave;
    import nn_axi_pkg::*;

    localparam int DW  = 16;
    localparam int NO  = 10;
    localparam int TMO = 20;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]       s_axi_awaddr;
    logic [2:0]       s_axi_awprot;
    logic             s_axi_awvalid;
    logic             s_axi_awready;
    logic [31:0]      s_axi_wdata;
    logic [3:0]       s_axi_wstrb;
    logic             s_axi_wvalid;
    logic             s_axi_wready;
    logic [1:0]       s_axi_bresp;
    logic             s_axi_bvalid;
    logic             s_axi_bready;
    logic [4:0]       s_axi_araddr;
    logic [2:0]       s_axi_arprot;
    logic             s_axi_arvalid;
    logic             s_axi_arready;
    logic [31:0]      s_axi_rdata;
    logic [1:0]       s_axi_rresp;
    logic             s_axi_rvalid;
    logic             s_axi_rready;
    logic             weightValid;
    logic [DW-1:0]    weightValue;
    logic             biasValid;
    logic [31:0]      biasValue;
    logic [31:0]      config_layer_num;
    logic [31:0]      config_neuron_num;
    logic             softReset;
    logic [31:0]      result;
    logic             result_valid;
    logic [NO*DW-1:0] neuron_out;
    logic             intr;
    logic [1:0]       dbg_wr_state;
    logic [1:0]       dbg_rd_state;

    nn_axi_lite_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .DATA_WIDTH(DW),
        .NUM_OUT(NO)
    ) dut (
        .s_axi_aclk(clk),
        .s_axi_aresetn(rst_n),
        .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .weightValid(weightValid),
        .weightValue(weightValue),
        .biasValid(biasValid),
        .biasValue(biasValue),
        .config_layer_num(config_layer_num),
        .config_neuron_num(config_neuron_num),
        .softReset(softReset),
        .result(result),
        .result_valid(result_valid),
        .neuron_out(neuron_out),
        .intr(intr),
        .dbg_wr_state(dbg_wr_state),
        .dbg_rd_state(dbg_rd_state)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model of the register map
    // ------------------------------------------------------------------
    logic signed [DW-1:0] nout_tbl [NO];
    logic [31:0]          exp_q[$];

    logic        m_weight_valid, m_bias_valid, m_soft, m_intr, m_bvalid, m_rvalid;
    logic [15:0] m_weight_value;
    logic [31:0] m_bias_value, m_layer, m_neuron, m_result;
    int          m_idx;

    logic        wr_hs, rd_hs, soft_now;
    logic [4:0]  wa, ra;
    logic [31:0] rd_val;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_weight_valid = 0; m_bias_valid = 0; m_soft = 0; m_intr = 0;
            m_bvalid = 0; m_rvalid = 0; m_weight_value = 0; m_bias_value = 0;
            m_layer = 0; m_neuron = 0; m_result = 0; m_idx = 0;
            exp_q.delete();
        end else begin
            wr_hs = s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready;
            rd_hs = s_axi_arvalid && s_axi_arready;
            wa = {s_axi_awaddr[4:2], 2'b00};
            ra = {s_axi_araddr[4:2], 2'b00};

            // Read value comes from the state before this edge.
            if (rd_hs) begin
                if (ra == ADDR_RESULT)      rd_val = m_result;
                else if (ra == ADDR_LAYER)  rd_val = m_layer;
                else if (ra == ADDR_NEURON) rd_val = m_neuron;
                else if (ra == ADDR_NOUT)   rd_val = int'(nout_tbl[m_idx]);
                else if (ra == ADDR_STATUS) rd_val = (m_idx != 0 ? 2 : 0) + (m_intr ? 1 : 0);
                else                        rd_val = 0;
                exp_q.push_back(rd_val);
            end

            soft_now       = wr_hs && (wa == ADDR_CTRL) && s_axi_wdata[0];
            m_weight_valid = wr_hs && (wa == ADDR_WEIGHT);
            m_bias_valid   = wr_hs && (wa == ADDR_BIAS);
            m_soft         = soft_now;
            if (m_weight_valid) m_weight_value = s_axi_wdata[15:0];
            if (m_bias_valid)   m_bias_value   = s_axi_wdata;
            if (wr_hs && wa == ADDR_LAYER)  m_layer  = s_axi_wdata;
            if (wr_hs && wa == ADDR_NEURON) m_neuron = s_axi_wdata;

            if (wr_hs) m_bvalid = 1;
            else if (m_bvalid && s_axi_bready) m_bvalid = 0;
            if (rd_hs) m_rvalid = 1;
            else if (m_rvalid && s_axi_rready) m_rvalid = 0;

            if (result_valid) m_intr = 1;
            else if ((rd_hs && ra == ADDR_RESULT) || soft_now) m_intr = 0;

            if (result_valid || soft_now) m_idx = 0;
            else if (rd_hs && ra == ADDR_NOUT) m_idx = (m_idx + 1) % NO;

            if (result_valid) m_result = result;
        end
    end

    // ------------------------------------------------------------------
    // Compare process and scoreboard
    // ------------------------------------------------------------------
    logic cmp_en = 1'b0;
    int   weight_pulses = 0;
    int   bias_pulses   = 0;
    int   soft_pulses   = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("weightValid", 32'(weightValid), 32'(m_weight_valid));
            check("weightValue", 32'(weightValue), 32'(m_weight_value));
            check("biasValid", 32'(biasValid), 32'(m_bias_valid));
            check("biasValue", biasValue, m_bias_value);
            check("config_layer_num", config_layer_num, m_layer);
            check("config_neuron_num", config_neuron_num, m_neuron);
            check("softReset", 32'(softReset), 32'(m_soft));
            check("intr", 32'(intr), 32'(m_intr));
            check("bvalid", 32'(s_axi_bvalid), 32'(m_bvalid));
            check("rvalid", 32'(s_axi_rvalid), 32'(m_rvalid));
            check("awready_eq_wready", 32'(s_axi_awready), 32'(s_axi_wready));
            check("bresp", 32'(s_axi_bresp), 32'(RESP_OKAY));
            check("rresp", 32'(s_axi_rresp), 32'(RESP_OKAY));
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_q.size() == 0) check("rdata_unexpected", s_axi_rdata, 32'hDEAD_BEEF);
                else check("rdata_model", s_axi_rdata, exp_q.pop_front());
            end
            if (weightValid) weight_pulses++;
            if (biasValid)   bias_pulses++;
            if (softReset)   soft_pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input int bdelay);
        int n;
        @(posedge clk); #1;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        while (!s_axi_awready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) check("aw_wait_timeout", 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        for (int i = 0; i < bdelay; i++) begin
            check("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            @(posedge clk); #1;
        end
        s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) check("b_wait_timeout", 32'(s_axi_bvalid), 32'd1);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int n;
        @(posedge clk); #1;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) check("ar_wait_timeout", 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        n = 0;
        while (!s_axi_rvalid && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) check("r_wait_timeout", 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic pulse_result(input logic [31:0] v);
        @(posedge clk); #1;
        result       = v;
        result_valid = 1'b1;
        @(posedge clk); #1;
        result_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    logic [31:0] d;
    logic [31:0] nout_exp [11];
    int          wp0, bp0, n;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        s_axi_awaddr = 0; s_axi_awprot = 0; s_axi_awvalid = 0;
        s_axi_wdata = 0; s_axi_wstrb = 4'hF; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_araddr = 0; s_axi_arprot = 0; s_axi_arvalid = 0; s_axi_rready = 0;
        result = 0; result_valid = 0;

        for (int i = 0; i < NO; i++) nout_tbl[i] = 16'(i * 'h111);
        nout_tbl[2] = 16'hF000;
        for (int i = 0; i < NO; i++) neuron_out[i*DW +: DW] = nout_tbl[i];
        nout_exp = '{32'h0, 32'h111, 32'hFFFF_F000, 32'h333, 32'h444, 32'h555,
                     32'h666, 32'h777, 32'h888, 32'h999, 32'h0};

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_wready", 32'(s_axi_wready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_weightValid", 32'(weightValid), 32'd0);
        check("rst_biasValid", 32'(biasValid), 32'd0);
        check("rst_layer", config_layer_num, 32'd0);
        check("rst_neuron", config_neuron_num, 32'd0);
        check("rst_softReset", 32'(softReset), 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        @(posedge clk); #3;
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Weight write with bready held off for three cycles
        wp0 = weight_pulses;
        axi_write(ADDR_WEIGHT, 32'h0000_ABCD, 3);
        check("weight_pulse_count", 32'(weight_pulses - wp0), 32'd1);
        check("weight_value_lit", 32'(weightValue), 32'h0000_ABCD);

        bp0 = bias_pulses;
        axi_write(ADDR_BIAS, 32'h8000_1234, 0);
        check("bias_pulse_count", 32'(bias_pulses - bp0), 32'd1);
        check("bias_value_lit", biasValue, 32'h8000_1234);

        // Layer / neuron configuration
        wp0 = weight_pulses; bp0 = bias_pulses;
        axi_write(ADDR_LAYER, 32'd3, 0);
        axi_write(ADDR_NEURON, 32'd17, 1);
        axi_read(ADDR_LAYER, d);  check("rd_layer_lit", d, 32'd3);
        axi_read(ADDR_NEURON, d); check("rd_neuron_lit", d, 32'd17);
        check("layer_out_lit", config_layer_num, 32'd3);
        check("neuron_out_lit", config_neuron_num, 32'd17);
        check("no_weight_pulse", 32'(weight_pulses - wp0), 32'd0);
        check("no_bias_pulse", 32'(bias_pulses - bp0), 32'd0);

        // Ignored offsets still answer, write-only offset reads as zero
        axi_write(ADDR_STATUS, 32'hFFFF_FFFF, 0);
        axi_read(ADDR_WEIGHT, d); check("rd_weight_zero", d, 32'd0);

        // Result / interrupt
        pulse_result(32'd7);
        check("intr_set_lit", 32'(intr), 32'd1);
        axi_read(ADDR_STATUS, d); check("status_pending_lit", d, 32'd1);
        axi_read(ADDR_RESULT, d); check("rd_result_lit", d, 32'd7);
        check("intr_clear_lit", 32'(intr), 32'd0);
        axi_read(ADDR_STATUS, d); check("status_clear_lit", d, 32'd0);

        // Neuron outputs, eleven reads wrap back to entry 0
        for (int i = 0; i < 11; i++) begin
            axi_read(ADDR_NOUT, d);
            check($sformatf("nout_%0d_lit", i), d, nout_exp[i]);
        end
        axi_read(ADDR_STATUS, d); check("status_idx_lit", d, 32'd2);

        // Result arriving on the same edge as the result-read handshake
        pulse_result(32'd5);
        fork
            axi_read(ADDR_RESULT, d);
            begin
                n = 0;
                do begin @(posedge clk); #1; n++; end while (!s_axi_arready && n < TMO);
                result       = 32'd9;
                result_valid = 1'b1;
                @(posedge clk); #1;
                result_valid = 1'b0;
            end
        join
        check("race_old_result_lit", d, 32'd5);
        check("race_intr_kept_lit", 32'(intr), 32'd1);
        axi_read(ADDR_RESULT, d); check("race_new_result_lit", d, 32'd9);
        check("race_intr_clear_lit", 32'(intr), 32'd0);

        // Control write clears a pending interrupt and pulses softReset
        pulse_result(32'd4);
        axi_read(ADDR_NOUT, d); check("nout_before_ctrl_lit", d, 32'd0);
        axi_write(ADDR_CTRL, 32'd1, 0);
        check("ctrl_intr_clear_lit", 32'(intr), 32'd0);
        check("soft_pulse_count", 32'(soft_pulses), 32'd1);
        axi_read(ADDR_STATUS, d); check("status_after_ctrl_lit", d, 32'd0);

        // Write and read channels together
        fork
            axi_write(ADDR_LAYER, 32'd42, 0);
            axi_read(ADDR_NEURON, d);
        join
        check("parallel_rd_lit", d, 32'd17);
        check("parallel_layer_lit", config_layer_num, 32'd42);

        // Reset while a response and an interrupt are pending
        pulse_result(32'd3);
        @(posedge clk); #1;
        s_axi_awaddr = ADDR_LAYER; s_axi_wdata = 32'd99;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < TMO) begin @(posedge clk); #1; n++; end
        if (n >= TMO) check("pre_reset_b_timeout", 32'(s_axi_bvalid), 32'd1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("pre_reset_layer_lit", config_layer_num, 32'd99);
        check("pre_reset_intr_lit", 32'(intr), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("async_intr", 32'(intr), 32'd0);
        check("async_layer", config_layer_num, 32'd0);
        check("async_neuron", config_neuron_num, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        axi_write(ADDR_NEURON, 32'd5, 1);
        check("post_reset_neuron_lit", config_neuron_num, 32'd5);
        axi_read(ADDR_NEURON, d); check("post_reset_rd_lit", d, 32'd5);
        axi_read(ADDR_RESULT, d); check("post_reset_result_lit", d, 32'd0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
